// File: rtl/mul4_seq_pkg.sv
// mul4_seq_pkg: state encoding and iteration constants shared by the multiplier.
package mul4_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int ITER = 4;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
endpackage

// File: rtl/sum4_v1.sv
// sum4_v1: 4-bit ripple-carry adder.
module sum4_v1 (
    output logic [3:0] S,
    output logic       c_out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in
);
    logic [4:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign c_out = c[4];
endmodule

// File: rtl/mul4_seq.sv
// mul4_seq: sequential 4x4 unsigned shift-and-add multiplier, one partial product per clock.
module mul4_seq
    import mul4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);
    state_t state, next;
    logic [3:0] m, q, acc, s;
    logic c;
    logic [CNT_W-1:0] cnt;
    logic [7:0] shifted;
    sum4_v1 u_add (
        .S    (s),
        .c_out(c),
        .A    (acc),
        .B    (q[0] ? m : 4'h0),
        .c_in (1'b0)
    );
    // adder carry lands in ACC[3] after the shift, so the 8-bit result never overflows
    assign shifted = {c, s, q[3:1]};
    always_comb begin
        next = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = (cnt == CNT_LAST) ? DONE : RUN;
            default: next = IDLE;
        endcase
        busy = (state == RUN);
        done = (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                m   <= A;
                q   <= B;
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                {acc, q} <= shifted;
                cnt      <= cnt + 1'b1;
                if (cnt == CNT_LAST) P <= shifted;
            end
        end
    end
endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: randomized and directed scoreboard bench for mul4_seq.
module tb_mul4_seq;
    logic clk = 0, reset = 1, start = 0;
    logic [3:0] A = 0, B = 0;
    logic [7:0] P;
    logic busy, done;
    logic [7:0] exp_q[$];
    int tests = 0, fails = 0;

    mul4_seq dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .P    (P),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got P=%0h with no request outstanding", P);
            end else begin
                chk("product", {24'h0, P}, {24'h0, exp_q.pop_front()});
            end
            chk("busy_with_done", {31'h0, busy}, 0);
        end
    end

    task automatic op(input logic [3:0] a, input logic [3:0] b);
        A = a;
        B = b;
        start = 1;
        exp_q.push_back({4'h0, a} * {4'h0, b});
        nxt();
        start = 0;
        A = 4'($urandom);
        B = 4'($urandom);
        repeat (4) nxt();
        chk("done_cycle5", {31'h0, done}, 1);
        nxt();
        chk("done_cycle6", {31'h0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (2) nxt();
        chk("rst_P", {24'h0, P}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        reset = 0;
        nxt();
        // 3*5 with exact cycle-by-cycle latency
        A = 3; B = 5; start = 1;
        exp_q.push_back(8'h0F);
        nxt();
        start = 0;
        for (int k = 1; k <= 4; k++) begin
            chk("run_busy", {31'h0, busy}, 1);
            chk("run_done", {31'h0, done}, 0);
            nxt();
        end
        chk("c5_done", {31'h0, done}, 1);
        chk("c5_busy", {31'h0, busy}, 0);
        nxt();
        chk("c6_done", {31'h0, done}, 0);
        chk("c6_P_held", {24'h0, P}, 8'h0F);
        op(15, 15);
        op(0, 9);
        op(7, 0);
        op(1, 1);
        // start during RUN must be ignored and not queued
        A = 6; B = 7; start = 1;
        exp_q.push_back(8'h2A);
        nxt();
        start = 0;
        nxt();
        A = 2; B = 2; start = 1;
        nxt();
        start = 0;
        repeat (2) nxt();
        chk("midstart_done", {31'h0, done}, 1);
        chk("midstart_P", {24'h0, P}, 8'h2A);
        seen = 0;
        repeat (8) begin
            nxt();
            if (done) seen++;
        end
        chk("not_queued", seen, 0);
        // reset during RUN aborts the operation
        A = 9; B = 9; start = 1;
        nxt();
        start = 0;
        repeat (2) nxt();
        reset = 1;
        nxt();
        reset = 0;
        chk("abort_P", {24'h0, P}, 0);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        nxt();
        chk("abort_no_done", {31'h0, done}, 0);
        op(9, 9);
        // start held high: accepted at cycles 0, 6, 12
        A = 4; B = 3; start = 1;
        exp_q.push_back(8'h0C);
        for (int k = 1; k <= 18; k++) begin
            nxt();
            if (k == 6 || k == 12) exp_q.push_back(8'h0C);
            if (k == 13) start = 0;
            chk("held_done", {31'h0, done}, {31'h0, k % 6 == 5});
            chk("held_busy", {31'h0, busy}, {31'h0, k % 6 >= 1 && k % 6 <= 4});
        end
        for (int n = 0; n < 20; n++) op(4'($urandom_range(15)), 4'($urandom_range(15)));
        repeat (3) nxt();
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
